// File: rtl/periph_bridge_pkg.sv
// rtl/periph_bridge_pkg.sv - shared state encoding and address-map constants for periph_bridge
package periph_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // daddr bit that selects peripheral space
  localparam int PERIPH_BIT = 9;

  // lowest daddr bit of the slot index
  localparam int SLOT_LSB = 10;

  // Slot index window: wide enough for the largest legal slot count (8), so
  // any index at or beyond NPERIPH is visible to the decoder and rejected
  // instead of aliasing onto a real slot.
  localparam int SLOT_FW = 3;

  // Read data returned to the CPU on a bus error
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/periph_bridge_timer.sv
// rtl/periph_bridge_timer.sv - ACCESS-phase timeout counter with terminal-count output
module bridge_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles since the last clear; clear has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The count includes the current enabled cycle, so terminal count fires on
  // the TIMEOUT-th enabled cycle after a clear.
  assign o_tc = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/periph_bridge.sv
// rtl/periph_bridge.sv - CPU data port to multi-slot peripheral bus bridge with timeout
module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int NPERIPH = 4,
  parameter int REG_AW  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            daddr,
  input  logic [31:0]            dwdata,
  input  logic [3:0]             we,
  input  logic                   dre,
  input  logic [31:0]            drdata,
  output logic [31:0]            rdata,
  output logic                   stall,
  output logic                   bus_err,
  output logic [NPERIPH-1:0]     psel,
  output logic                   penable,
  output logic [REG_AW-1:0]      paddr,
  output logic [31:0]            pwdata,
  output logic [3:0]             pwe,
  input  logic [NPERIPH-1:0]     pready,
  input  logic [NPERIPH*32-1:0]  prdata
);

  state_e               r_state;
  state_e               w_next;
  logic [SLOT_FW-1:0]   r_slot;
  logic [REG_AW-1:0]    r_paddr;
  logic [31:0]          r_pwdata;
  logic [3:0]           r_pwe;
  logic [31:0]          r_rdata_q;

  logic                 w_periph;
  logic                 w_req;
  logic [SLOT_FW-1:0]   w_slot;
  logic                 w_slot_ok;
  logic [NPERIPH-1:0]   w_slot_onehot;
  logic [31:0]          w_prdata_sel;
  logic                 w_pready_sel;
  logic                 w_in_access;
  logic                 w_bus_active;
  logic                 w_timer_tc;
  logic                 w_unused_daddr;

  // Only the peripheral flag, slot index and word address matter here;
  // the rest of daddr belongs to the memory side.
  assign w_unused_daddr = ^daddr;

  assign w_periph  = daddr[PERIPH_BIT];
  assign w_req     = w_periph && ((we != 4'b0000) || dre);
  assign w_slot    = daddr[SLOT_LSB +: SLOT_FW];
  assign w_slot_ok = (int'(w_slot) < NPERIPH);

  assign w_in_access  = (r_state == ST_ACCESS);
  assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

  // Decode the captured slot into a one-hot select and pick its read data
  always_comb begin
    w_slot_onehot = '0;
    w_prdata_sel  = '0;
    for (int k = 0; k < NPERIPH; k++) begin
      if (r_slot == SLOT_FW'(k)) begin
        w_slot_onehot[k] = 1'b1;
        w_prdata_sel     = prdata[k*32 +: 32];
      end
    end
  end

  // Ready from slots other than the selected one never reaches the FSM
  assign w_pready_sel = |(pready & w_slot_onehot);

  bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_in_access),
    .i_enable (w_in_access),
    .o_tc     (w_timer_tc)
  );

  // Next-state selection; ready in the last allowed ACCESS cycle still wins
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next = w_slot_ok ? ST_SETUP : ST_ERR;
        end
      end
      ST_SETUP: begin
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_pready_sel) begin
          w_next = ST_DONE;
        end else if (w_timer_tc) begin
          w_next = ST_ERR;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction without an error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the request when it is accepted in IDLE; held for the whole transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot   <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwe    <= '0;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_slot   <= w_slot;
      r_paddr  <= daddr[2 +: REG_AW];
      r_pwdata <= dwdata;
      r_pwe    <= we;
    end
  end

  // Latch the selected slot's read data on completion, reads and writes alike
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata_q <= '0;
    end else if (w_in_access && w_pready_sel) begin
      r_rdata_q <= w_prdata_sel;
    end
  end

  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
  assign pwe     = r_pwe;
  assign psel    = w_bus_active ? w_slot_onehot : '0;
  assign penable = w_in_access;
  assign bus_err = (r_state == ST_ERR);
  assign stall   = ((r_state == ST_IDLE) && w_req) || w_bus_active;

  // Return path: completed data in DONE, error pattern in ERR, memory otherwise
  always_comb begin
    rdata = drdata;
    if (r_state == ST_DONE) begin
      rdata = r_rdata_q;
    end else if (r_state == ST_ERR) begin
      rdata = ERR_DATA;
    end
  end

endmodule
